// File: rtl/game_pkg.sv
// Shared constants, state encoding and player-count clamp for the turn scheduler.
package game_pkg;
    localparam int TRACK_LEN   = 24;
    localparam int POS_W       = 5;
    localparam int LAP_W       = 3;
    localparam int MAX_PLAYERS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [2:0] clamp_players(input logic [2:0] n);
        if (n < 3'd2)      return 3'd2;
        else if (n > 3'd4) return 3'd4;
        else               return n;
    endfunction
endpackage

// File: rtl/turn_scheduler_if.sv
// Game control bus: start/guess inputs and turn/position/winner status outputs.
interface turn_scheduler_if;
    import game_pkg::*;
    logic                         start;
    logic [2:0]                   n_players;
    logic                         guess_valid;
    logic                         guess_hit;
    logic                         ready;
    logic [1:0]                   cur_player;
    logic [MAX_PLAYERS*POS_W-1:0] pos_flat;
    logic                         game_over;
    logic [1:0]                   winner;

    modport master (output start, n_players, guess_valid, guess_hit,
                    input  ready, cur_player, pos_flat, game_over, winner);
    modport slave  (input  start, n_players, guess_valid, guess_hit,
                    output ready, cur_player, pos_flat, game_over, winner);
endinterface

// File: rtl/track_pos_counter.sv
// One player's track position with wrap at the last tile and a saturating lap count.
module track_pos_counter
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [POS_W-1:0] pos,
    output logic [LAP_W-1:0] laps
);
    logic wrap;
    assign wrap = inc && (pos == POS_W'(TRACK_LEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos  <= '0;
            laps <= '0;
        end else if (clr) begin
            pos  <= '0;
            laps <= '0;
        end else if (inc) begin
            pos <= wrap ? '0 : pos + 1'b1;
            if (wrap && laps != '1) laps <= laps + 1'b1;
        end
    end
endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer for 2-4 players on the track; a hit keeps the turn, a miss passes it.
// Optional turn time limit under TURN_TIMEOUT_EN (an expired turn counts as a miss).
module turn_scheduler
    import game_pkg::*;
#(
    parameter int LAPS_TO_WIN = 1
`ifdef TURN_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 50000000
`endif
) (
    input logic              clk,
    input logic              rst,
    turn_scheduler_if.slave  bus
);
    state_t     state, state_n;
    logic [1:0] cur_player, cur_n;
    logic [1:0] winner, win_n;
    logic [2:0] n_latched, nlat_n;
    logic       clr, hit_inc, timeout;
    logic [2:0] nxt;

    logic [MAX_PLAYERS-1:0]            inc;
    logic [MAX_PLAYERS-1:0][POS_W-1:0] pos;
    logic [MAX_PLAYERS-1:0][LAP_W-1:0] laps;

    for (genvar k = 0; k < MAX_PLAYERS; k++) begin : g_track
        assign inc[k] = hit_inc && (cur_player == 2'(k));
        track_pos_counter u_cnt (
            .clk  (clk),
            .rst  (rst),
            .clr  (clr),
            .inc  (inc[k]),
            .pos  (pos[k]),
            .laps (laps[k])
        );
    end

`ifdef TURN_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tcnt;

    assign timeout = (state == TURN) && !bus.guess_valid && (tcnt == TW'(TIMEOUT_CYC - 1));

    // Held at zero outside TURN, so every entry into TURN starts a fresh count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                          tcnt <= '0;
        else if (state != TURN || bus.guess_valid || timeout) tcnt <= '0;
        else                                               tcnt <= tcnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    assign nxt = {1'b0, cur_player} + 3'd1;

    always_comb begin
        state_n = state;
        cur_n   = cur_player;
        win_n   = winner;
        nlat_n  = n_latched;
        clr     = 1'b0;
        hit_inc = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = TURN;
                    cur_n   = 2'd0;
                    nlat_n  = clamp_players(bus.n_players);
                    clr     = 1'b1;
                end
            end
            TURN: begin
                if (bus.guess_valid && bus.guess_hit) begin
                    hit_inc = 1'b1;
                    state_n = UPDATE;
                end else if (bus.guess_valid || timeout) begin
                    cur_n = (nxt >= n_latched) ? 2'd0 : nxt[1:0];
                end
            end
            UPDATE: begin
                if (laps[cur_player] == LAP_W'(LAPS_TO_WIN)) begin
                    state_n = DONE;
                    win_n   = cur_player;
                end else begin
                    state_n = TURN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cur_player <= 2'd0;
            winner     <= 2'd0;
            n_latched  <= 3'd2;
        end else begin
            state      <= state_n;
            cur_player <= cur_n;
            winner     <= win_n;
            n_latched  <= nlat_n;
        end
    end

    assign bus.ready      = (state == TURN);
    assign bus.game_over  = (state == DONE);
    assign bus.cur_player = cur_player;
    assign bus.winner     = winner;
    assign bus.pos_flat   = pos;
endmodule

// File: tb/tb_turn_scheduler.sv
// Directed vector bench for turn_scheduler: table of one-cycle actions plus multi-cycle sequences.
module tb_turn_scheduler;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    turn_scheduler_if bus ();

    turn_scheduler #(
        .LAPS_TO_WIN (1)
`ifdef TURN_TIMEOUT_EN
        , .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        s;
        logic [2:0]  n;
        logic        gv;
        logic        gh;
        logic [1:0]  cur;
        logic [19:0] pos;
        logic        rdy;
        logic        over;
        logic [1:0]  win;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    function automatic logic [19:0] P(input int p0, input int p1, input int p2, input int p3);
        return {5'(p3), 5'(p2), 5'(p1), 5'(p0)};
    endfunction

    function automatic vec_t mk(input logic s, input logic [2:0] n, input logic gv, input logic gh,
                                input logic [1:0] cur, input logic [19:0] pos,
                                input logic rdy, input logic over, input logic [1:0] win);
        vec_t v;
        v.s = s; v.n = n; v.gv = gv; v.gh = gh;
        v.cur = cur; v.pos = pos; v.rdy = rdy; v.over = over; v.win = win;
        return v;
    endfunction

    // Winner is only meaningful with game_over, so it is compared when over (or forced) is expected.
    task automatic expect_state(input string name, input logic [1:0] cur, input logic [19:0] pos,
                                input logic rdy, input logic over, input logic [1:0] win,
                                input logic chk_win);
        logic [25:0] act, exp;
        act = {bus.cur_player, bus.pos_flat, bus.ready, bus.game_over,
               (chk_win || over) ? bus.winner : 2'b00};
        exp = {cur, pos, rdy, over, (chk_win || over) ? win : 2'b00};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got cur=%0d pos=%h rdy=%b over=%b win=%0d, expected cur=%0d pos=%h rdy=%b over=%b win=%0d",
                     name, bus.cur_player, bus.pos_flat, bus.ready, bus.game_over, bus.winner,
                     cur, pos, rdy, over, win);
        end
    endtask

    task automatic step(input logic s, input logic [2:0] n, input logic gv, input logic gh);
        bus.start       = s;
        bus.n_players   = n;
        bus.guess_valid = gv;
        bus.guess_hit   = gh;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.guess_valid = 1'b0;
        bus.guess_hit   = 1'b0;
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].n, tbl[i].gv, tbl[i].gh);
            expect_state($sformatf("%s[%0d]", tag, i), tbl[i].cur, tbl[i].pos,
                         tbl[i].rdy, tbl[i].over, tbl[i].win, 1'b0);
        end
        tbl.delete();
    endtask

    logic [1:0] to_cur;

    initial begin
        bus.start = 1'b0; bus.n_players = 3'd0; bus.guess_valid = 1'b0; bus.guess_hit = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_state("reset", 2'd0, P(0,0,0,0), 1'b0, 1'b0, 2'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // IDLE guess ignored, 3-player misses, mid-game start ignored, hits keep the turn
        tbl.push_back(mk(0,0,1,1, 0,P(0,0,0,0),0,0,0));
        tbl.push_back(mk(1,3,0,0, 0,P(0,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,0, 1,P(0,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,0, 2,P(0,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,0, 0,P(0,0,0,0),1,0,0));
        tbl.push_back(mk(1,2,0,0, 0,P(0,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,1, 0,P(1,0,0,0),0,0,0));
        tbl.push_back(mk(0,0,1,1, 0,P(1,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,1, 0,P(2,0,0,0),0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,P(2,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,1, 0,P(3,0,0,0),0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,P(3,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,1, 0,P(4,0,0,0),0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,P(4,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,1, 0,P(5,0,0,0),0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,P(5,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,0, 1,P(5,0,0,0),1,0,0));
        run_tbl("game1");

        // Player 1 walks to the last tile, then wraps and wins
        for (int i = 0; i < 23; i++) begin
            step(0, 0, 1, 1);
            step(0, 0, 0, 0);
        end
        expect_state("p1_at_23", 2'd1, P(5,23,0,0), 1'b1, 1'b0, 2'd0, 1'b0);
        step(0, 0, 1, 1);
        expect_state("p1_wrap", 2'd1, P(5,0,0,0), 1'b0, 1'b0, 2'd0, 1'b0);
        step(0, 0, 0, 0);
        expect_state("game_over", 2'd1, P(5,0,0,0), 1'b0, 1'b1, 2'd1, 1'b1);
        step(0, 0, 1, 1);
        expect_state("done_guess", 2'd1, P(5,0,0,0), 1'b0, 1'b1, 2'd1, 1'b1);
        step(0, 0, 1, 0);
        expect_state("done_miss", 2'd1, P(5,0,0,0), 1'b0, 1'b1, 2'd1, 1'b1);

        // Restart from DONE with start+guess together; n_players=7 clamps to 4
        tbl.push_back(mk(1,7,1,1, 0,P(0,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,0, 1,P(0,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,0, 2,P(0,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,0, 3,P(0,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,0, 0,P(0,0,0,0),1,0,0));
        run_tbl("game2");

        // Asynchronous reset mid-turn
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 1);
            step(0, 0, 0, 0);
        end
        expect_state("p0_at_10", 2'd0, P(10,0,0,0), 1'b1, 1'b0, 2'd0, 1'b0);
        #1 rst = 1'b0;
        #1;
        expect_state("async_rst", 2'd0, P(0,0,0,0), 1'b0, 1'b0, 2'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // n_players=1 clamps to 2
        tbl.push_back(mk(1,1,0,0, 0,P(0,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,0, 1,P(0,0,0,0),1,0,0));
        tbl.push_back(mk(0,0,1,0, 0,P(0,0,0,0),1,0,0));
        run_tbl("game3");

        // Idle turn: 7 quiet cycles never expire; the 8th passes the turn only with the timeout
        repeat (7) step(0, 0, 0, 0);
        expect_state("idle7", 2'd0, P(0,0,0,0), 1'b1, 1'b0, 2'd0, 1'b0);
        step(0, 0, 0, 0);
`ifdef TURN_TIMEOUT_EN
        to_cur = 2'd1;
`else
        to_cur = 2'd0;
`endif
        expect_state("idle8", to_cur, P(0,0,0,0), 1'b1, 1'b0, 2'd0, 1'b0);
        repeat (7) step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        expect_state("guess_on_8th", to_cur, (to_cur == 2'd1) ? P(0,1,0,0) : P(1,0,0,0),
                     1'b0, 1'b0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
